mini_calc_seq: RTL

Parametrised, handshaked successor of the four-operation mini calculator. It widens operands to `WIDTH` bits and registers every result. Add/sub and min/max complete in one cycle; multiply and divide are computed iteratively over `WIDTH` cycles by a shared shift/add datapath. It sits between an instruction source and a result consumer using valid/ready on both sides, and adds divide-by-zero and carry/borrow status.

---
 rtl/mini_calc_pkg.sv | 17 +
 rtl/mini_calc_iter.sv | 44 ++++
 rtl/mini_calc_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mini_calc_pkg.sv
// Shared definitions for the sequential mini calculator: opcodes and FSM states.
package mini_calc_pkg;

    localparam logic [3:0] OP_NOP     = 4'b1111;
    localparam logic [3:0] OP_ADD_SUB = 4'b0111;
    localparam logic [3:0] OP_MIN_MAX = 4'b1011;
    localparam logic [3:0] OP_MUL     = 4'b1101;
    localparam logic [3:0] OP_DIV     = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/mini_calc_iter.sv
// One iteration of the shared multiply/divide datapath on a 2*WIDTH accumulator.
// Multiply: accumulator starts as {0, multiplier}; the low bit selects an add of
// the multiplicand into the upper half, then everything shifts right.
// Divide: accumulator starts as {0, dividend}; shift left, try subtracting the
// divisor from the upper half, keep the difference if it fits and shift in a 1.
module mini_calc_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // The partial remainder after the left shift needs one extra bit before the compare.
    assign w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
    assign w_rem  = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge   = (w_rem >= {1'b0, i_opnd});
    assign w_diff = w_rem[WIDTH-1:0] - i_opnd;

    // Select the next accumulator value for the active operation.
    always_comb begin
        o_acc = '0;
        if (i_div) begin
            if (w_ge) begin
                o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (i_acc[0]) begin
                o_acc = {w_sum, i_acc[WIDTH-1:1]};
            end else begin
                o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mini_calc_seq.sv
// Handshaked calculator: single-cycle add/sub, min/max, NOP and divide-by-zero;
// WIDTH-step iterative multiply and divide. All results are registered.
module mini_calc_seq
    import mini_calc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int INSTR_WIDTH = 4
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [INSTR_WIDTH-1:0] Instruction,
    input  logic [WIDTH-1:0]       InputA,
    input  logic [WIDTH-1:0]       InputB,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [WIDTH-1:0]       OutputA,
    output logic [WIDTH-1:0]       OutputB,
    output logic                   Carry,
    output logic                   Borrow,
    output logic                   DivZero
);

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_out_a;
    logic [WIDTH-1:0]   r_out_b;
    logic               r_carry;
    logic               r_borrow;
    logic               r_divzero;

    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    state_t             w_load_state;
    logic [2*WIDTH-1:0] w_acc_init;
    logic [WIDTH-1:0]   w_opnd_init;
    logic [WIDTH-1:0]   w_res_a;
    logic [WIDTH-1:0]   w_res_b;
    logic               w_res_c;
    logic               w_res_br;
    logic               w_res_dz;

    // OutReady -> InReady is the only combinational path through the block.
    assign InReady  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && OutReady);
    assign w_accept = InValid && InReady;
    assign OutValid = (r_state == ST_DONE);
    assign OutputA  = r_out_a;
    assign OutputB  = r_out_b;
    assign Carry    = r_carry;
    assign Borrow   = r_borrow;
    assign DivZero  = r_divzero;

    assign w_sum = {1'b0, InputA} + {1'b0, InputB};

    mini_calc_iter #(.WIDTH(WIDTH)) u_iter (
        .i_div  (r_state == ST_DIV),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_next)
    );

    // Decode the incoming request: immediate result, or iteration seed and target state.
    always_comb begin
        w_res_a      = '0;
        w_res_b      = '0;
        w_res_c      = 1'b0;
        w_res_br     = 1'b0;
        w_res_dz     = 1'b0;
        w_load_state = ST_DONE;
        w_acc_init   = {{WIDTH{1'b0}}, InputB};
        w_opnd_init  = InputA;
        case (Instruction)
            INSTR_WIDTH'(OP_ADD_SUB): begin
                w_res_a  = w_sum[WIDTH-1:0];
                w_res_b  = InputA - InputB;
                w_res_c  = w_sum[WIDTH];
                w_res_br = (InputA < InputB);
            end
            INSTR_WIDTH'(OP_MIN_MAX): begin
                if (InputA >= InputB) begin
                    w_res_a = InputA;
                    w_res_b = InputB;
                end else begin
                    w_res_a = InputB;
                    w_res_b = InputA;
                end
            end
            INSTR_WIDTH'(OP_MUL): begin
                w_load_state = ST_MUL;
            end
            INSTR_WIDTH'(OP_DIV): begin
                if (InputB == '0) begin
                    w_res_a  = '1;
                    w_res_b  = InputA;
                    w_res_dz = 1'b1;
                end else begin
                    w_load_state = ST_DIV;
                    w_acc_init   = {{WIDTH{1'b0}}, InputA};
                    w_opnd_init  = InputB;
                end
            end
            default: begin
                w_res_a = '0;
                w_res_b = '0;
            end
        endcase
    end

    // FSM, iteration counter, accumulator and registered result outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_out_a   <= '0;
            r_out_b   <= '0;
            r_carry   <= 1'b0;
            r_borrow  <= 1'b0;
            r_divzero <= 1'b0;
        end else if (w_accept) begin
            // Accept happens only in IDLE or in DONE while the consumer takes the result.
            r_state <= w_load_state;
            if (w_load_state == ST_DONE) begin
                r_out_a   <= w_res_a;
                r_out_b   <= w_res_b;
                r_carry   <= w_res_c;
                r_borrow  <= w_res_br;
                r_divzero <= w_res_dz;
            end else begin
                r_cnt  <= CW'(WIDTH - 1);
                r_acc  <= w_acc_init;
                r_opnd <= w_opnd_init;
            end
        end else begin
            case (r_state)
                ST_MUL, ST_DIV: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == '0) begin
                        r_state   <= ST_DONE;
                        r_out_a   <= w_acc_next[WIDTH-1:0];
                        r_out_b   <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_carry   <= 1'b0;
                        r_borrow  <= 1'b0;
                        r_divzero <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
